// File: rtl/staged_input_bank.sv
// staged_input_bank: N-channel ping-pong input staging with entry counting,
// per-channel overflow flags and TMUX frame-length checking. One BX of words
// is written into the write bank while the downstream module reads the
// previously completed BX from the other bank.
module staged_input_bank #(
  parameter int NCH    = 6,
  parameter int DATA_W = 36,
  parameter int ADDR_W = 6,
  parameter int TMUX   = 36
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_proc,
  input  logic [2:0]                BX,
  input  logic [1:0]                start,
  output logic [1:0]                done,
  input  logic [NCH-1:0]            valid_in,
  input  logic [NCH*DATA_W-1:0]     data_in,
  input  logic [NCH*ADDR_W-1:0]     read_add,
  output logic [NCH*DATA_W-1:0]     data_out,
  output logic [NCH-1:0]            rd_valid,
  output logic [NCH*(ADDR_W+1)-1:0] number_out,
  output logic [2:0]                BX_out,
  output logic [NCH-1:0]            overflow,
  output logic                      sync_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam int FC_W  = $clog2(TMUX);

  logic                soft_rst;
  logic                frame_start;

  logic                wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]    wr_ptr_q [NCH];
  logic [CNT_W-1:0]    wr_ptr_d [NCH];
  logic [CNT_W-1:0]    num_q [NCH];
  logic [CNT_W-1:0]    num_d [NCH];
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                primed_q, primed_d;
  logic [1:0]          done_q, done_d;
  logic [2:0]          bx_lat_q, bx_lat_d;
  logic [2:0]          bx_out_q, bx_out_d;
  logic [NCH-1:0]      ovf_q, ovf_d;
  logic [NCH-1:0]      rd_valid_q, rd_valid_d;
  logic                sync_err_q, sync_err_d;
  logic [DATA_W-1:0]   dout_q [NCH];

  logic [NCH-1:0]      we;
  logic [ADDR_W:0]     waddr [NCH];
  logic [ADDR_W:0]     raddr [NCH];

  // Bank is the MSB of the per-channel RAM address.
  logic [DATA_W-1:0]   mem [NCH][2*DEPTH];

  // Soft reset has priority over frame start and writes.
  assign soft_rst    = start[1];
  assign frame_start = start[0] & ~start[1];

  // Next-state for bank control, pointers, counters, flags and write port.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    frame_cnt_d = frame_cnt_q;
    primed_d    = primed_q;
    bx_lat_d    = bx_lat_q;
    bx_out_d    = bx_out_q;
    ovf_d       = ovf_q;
    sync_err_d  = sync_err_q;
    done_d      = {soft_rst, 1'b0};
    we          = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      num_d[c]    = num_q[c];
      waddr[c]    = {wr_bank_q, wr_ptr_q[c][ADDR_W-1:0]};
    end

    if (soft_rst) begin
      wr_bank_d   = 1'b0;
      frame_cnt_d = '0;
      primed_d    = 1'b0;
      bx_lat_d    = '0;
      bx_out_d    = '0;
      ovf_d       = '0;
      sync_err_d  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_d[c] = '0;
        num_d[c]    = '0;
      end
    end else begin
      if (frame_start) begin
        wr_bank_d   = ~wr_bank_q;
        bx_lat_d    = BX;
        bx_out_d    = bx_lat_q;
        primed_d    = 1'b1;
        frame_cnt_d = '0;
        done_d[0]   = primed_q;
      end else if (!en_proc) begin
        frame_cnt_d = '0;
      end else if (frame_cnt_q == FC_W'(TMUX-1)) begin
        sync_err_d  = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end

      for (int c = 0; c < NCH; c++) begin
        if (frame_start) begin
          // A word arriving with the frame start opens the new bank at address 0.
          num_d[c]    = wr_ptr_q[c];
          waddr[c]    = {~wr_bank_q, {ADDR_W{1'b0}}};
          we[c]       = en_proc & valid_in[c];
          wr_ptr_d[c] = (en_proc & valid_in[c]) ? CNT_W'(1) : '0;
        end else if (en_proc && valid_in[c]) begin
          if (wr_ptr_q[c] == CNT_W'(DEPTH)) begin
            ovf_d[c] = 1'b1;
          end else begin
            we[c]       = 1'b1;
            wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
          end
        end
      end
    end

    // Reads follow the bank being released this clock, so a read issued in
    // the swap clock already sees the just-completed frame.
    for (int c = 0; c < NCH; c++) begin
      raddr[c]      = {~wr_bank_d, read_add[c*ADDR_W +: ADDR_W]};
      rd_valid_d[c] = {1'b0, read_add[c*ADDR_W +: ADDR_W]} < num_d[c];
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
      primed_q    <= 1'b0;
      done_q      <= '0;
      bx_lat_q    <= '0;
      bx_out_q    <= '0;
      ovf_q       <= '0;
      rd_valid_q  <= '0;
      sync_err_q  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        num_q[c]    <= '0;
        dout_q[c]   <= '0;
      end
    end else begin
      wr_bank_q   <= wr_bank_d;
      frame_cnt_q <= frame_cnt_d;
      primed_q    <= primed_d;
      done_q      <= done_d;
      bx_lat_q    <= bx_lat_d;
      bx_out_q    <= bx_out_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      sync_err_q  <= sync_err_d;
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        num_q[c]    <= num_d[c];
        dout_q[c]   <= mem[c][raddr[c]];
      end
    end
  end

  // Per-channel RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (we[c]) mem[c][waddr[c]] <= data_in[c*DATA_W +: DATA_W];
    end
  end

  // Flatten per-channel registers onto the packed output buses.
  always_comb begin
    data_out   = '0;
    number_out = '0;
    for (int c = 0; c < NCH; c++) begin
      data_out[c*DATA_W +: DATA_W]  = dout_q[c];
      number_out[c*CNT_W +: CNT_W]  = num_q[c];
    end
  end

  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign BX_out   = bx_out_q;
  assign overflow = ovf_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_staged_input_bank.sv
// Directed bench for staged_input_bank with hand-computed expectations.
module tb_staged_input_bank;

  localparam int NCH    = 6;
  localparam int DATA_W = 36;
  localparam int ADDR_W = 6;
  localparam int TMUX   = 36;
  localparam int CW     = ADDR_W + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  en_proc;
  logic [2:0]            BX;
  logic [1:0]            start;
  logic [1:0]            done;
  logic [NCH-1:0]        valid_in;
  logic [NCH*DATA_W-1:0] data_in;
  logic [NCH*ADDR_W-1:0] read_add;
  logic [NCH*DATA_W-1:0] data_out;
  logic [NCH-1:0]        rd_valid;
  logic [NCH*CW-1:0]     number_out;
  logic [2:0]            BX_out;
  logic [NCH-1:0]        overflow;
  logic                  sync_err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  staged_input_bank #(.NCH(NCH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TMUX(TMUX)) dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .BX(BX), .start(start), .done(done),
    .valid_in(valid_in), .data_in(data_in), .read_add(read_add), .data_out(data_out),
    .rd_valid(rd_valid), .number_out(number_out), .BX_out(BX_out), .overflow(overflow),
    .sync_err(sync_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [DATA_W-1:0] d);
    valid_in[c] = 1'b1;
    data_in[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_ra(input int c, input logic [ADDR_W-1:0] a);
    read_add[c*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [CW-1:0] num(input int c);
    return number_out[c*CW +: CW];
  endfunction

  function automatic logic [DATA_W-1:0] dout(input int c);
    return data_out[c*DATA_W +: DATA_W];
  endfunction

  initial begin
    reset = 1'b1; en_proc = 1'b0; BX = 3'd0; start = 2'b00;
    valid_in = '0; data_in = '0; read_add = '0;
    tick(); tick();
    chk("rst_done", done, 2'b00);
    chk("rst_number", number_out, 0);
    chk("rst_dout", |data_out, 0);
    chk("rst_rdvalid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_syncerr", sync_err, 0);
    chk("rst_bx", BX_out, 0);

    reset = 1'b0; en_proc = 1'b1;
    tick();

    // Basic frame: 5 words on ch0, swap exactly TMUX clocks later.
    BX = 3'd3; start = 2'b01; tick(); start = 2'b00; BX = 3'd5;
    chk("t1_first_no_done", done, 2'b00);
    for (int k = 0; k < 5; k++) begin
      put(0, 36'hA00000000 + 36'(k)); tick();
    end
    valid_in = '0;
    repeat (30) tick();
    start = 2'b01; tick(); start = 2'b00;
    chk("t1_done", done, 2'b01);
    chk("t1_num0", num(0), 5);
    chk("t1_num1", num(1), 0);
    chk("t1_bx", BX_out, 3);
    chk("t1_syncerr", sync_err, 0);
    for (int k = 0; k < 6; k++) begin
      set_ra(0, ADDR_W'(k)); tick();
      if (k == 0) chk("t1_done_pulse", done, 2'b00);
      if (k < 5) begin
        chk("t1_rd_data", dout(0), 36'hA00000000 + 36'(k));
        chk("t1_rd_valid", rd_valid[0], 1);
      end else begin
        chk("t1_rd_past_end", rd_valid[0], 0);
      end
    end

    // Write in the swap clock goes to address 0 of the new bank.
    put(1, 36'h111); tick(); valid_in = '0;
    set_ra(1, 0);
    put(1, 36'hABC); start = 2'b01; tick(); start = 2'b00; valid_in = '0;
    chk("t3_num1_old", num(1), 1);
    chk("t3_old_word", dout(1), 36'h111);
    chk("t3_num0", num(0), 0);
    repeat (3) tick();
    start = 2'b01; tick(); start = 2'b00;
    chk("t3_num1_new", num(1), 1);
    chk("t3_new_word", dout(1), 36'hABC);
    chk("t3_rdvalid", rd_valid[1], 1);

    // Overflow on ch2 (70 writes into a 64-deep bank); frame also runs long.
    for (int i = 0; i < 70; i++) begin
      put(2, 36'h200 + 36'(i)); tick();
    end
    valid_in = '0;
    chk("t2_ovf_pre", overflow, 6'b000100);
    chk("t2_long_frame", sync_err, 1);
    set_ra(2, 6'd63);
    start = 2'b01; tick(); start = 2'b00;
    chk("t2_num2", num(2), 64);
    chk("t2_ovf", overflow, 6'b000100);
    chk("t2_last_word", dout(2), 36'h23F);
    chk("t2_last_valid", rd_valid[2], 1);

    // Soft reset and frame start together: soft reset wins.
    start = 2'b11; tick(); start = 2'b00;
    chk("t6_done", done, 2'b10);
    chk("t6_number", number_out, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_syncerr", sync_err, 0);
    chk("t6_bx", BX_out, 0);

    // Frame without start: sync_err on the 36th counting clock.
    tick();
    chk("t6_done_clear", done, 2'b00);
    repeat (34) tick();
    chk("t4_no_err_35", sync_err, 0);
    tick();
    chk("t4_err_36", sync_err, 1);
    repeat (4) tick();
    chk("t4_err_sticky", sync_err, 1);
    start = 2'b10; tick(); start = 2'b00;
    chk("t4_done1", done, 2'b10);
    chk("t4_err_clear", sync_err, 0);
    chk("t4_number", number_out, 0);

    // Async reset mid-frame with writes in flight.
    start = 2'b01; tick(); start = 2'b00;
    chk("t5_unprimed", done, 2'b00);
    for (int k = 0; k < 3; k++) begin
      put(0, 36'hC00 + 36'(k)); tick();
    end
    valid_in = '0;
    set_ra(0, 0);
    start = 2'b01; tick(); start = 2'b00;
    chk("t5_done", done, 2'b01);
    chk("t5_num0", num(0), 3);
    chk("t5_swap_read", dout(0), 36'hC00);
    chk("t5_swap_valid", rd_valid[0], 1);
    put(0, 36'hDEAD);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_done", done, 2'b00);
    chk("t5_async_num", number_out, 0);
    chk("t5_async_dout", |data_out, 0);
    chk("t5_async_rdvalid", rd_valid, 0);
    tick(); tick();
    reset = 1'b0; valid_in = '0;
    tick();
    start = 2'b01; tick(); start = 2'b00;
    chk("t5_no_done_after_rst", done, 2'b00);
    chk("t5_num0_after_rst", num(0), 0);
    tick();
    chk("t5_still_no_done", done, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
